fetch_stage: RTL

// - Y86-64 pipeline fetch stage; producer side of the F->D pipeline register interface.
// - Holds the predicted-PC register and fetches instructions over a valid/ready instruction-memory port.
// - Splits each instruction into f_icode/f_ifun/f_rA/f_rB/f_valC/f_valP, predicts the next PC, and applies redirects from M (mispredicted jXX) and W (ret).
// - Drives f_valid so pipeline control can stall or bubble D while a fetch is outstanding.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage and the memory system.
// The fetch stage is the master: it drives the request and the byte address;
// the memory answers with ready, ten bytes of data, and an address-error flag.
interface fetch_stage_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [79:0] imem_rdata;
    logic        imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: holds the predicted PC and fetches one instruction at a
// time over the imem port. It splits the instruction into fields, computes
// valP and the predicted PC, and applies redirects from M (mispredicted jXX)
// and W (ret).
// Optional feature: define FETCH_IFUN_CHECK_EN to flag invalid ifun codes as INS.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          f_stall_i,
    input  logic [3:0]    m_icode_i,
    input  logic          m_cnd_i,
    input  logic [63:0]   m_vala_i,
    input  logic [3:0]    w_icode_i,
    input  logic [63:0]   w_valm_i,
    fetch_stage_if.master imem,
    output logic          f_valid_o,
    output logic [3:0]    f_icode_o,
    output logic [3:0]    f_ifun_o,
    output logic [3:0]    f_ra_o,
    output logic [3:0]    f_rb_o,
    output logic [63:0]   f_valc_o,
    output logic [63:0]   f_valp_o,
    output logic [63:0]   f_predpc_o,
    output logic [2:0]    f_stat_o
);

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [1:0] {StReq, StDrop, StHold, StHalted} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] tgt_q, tgt_d;
    logic [79:0] data_q, data_d;
    logic        err_q, err_d;

    logic        redirect;
    logic [63:0] redirect_pc;

    logic [3:0]  dec_icode, dec_ifun;
    logic        need_regs, need_valc, ifun_bad;
    logic [63:0] dec_valc, dec_valp;
    logic [2:0]  dec_stat;

    // Redirect sources; a mispredicted branch in M wins over a ret in W.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        if (m_icode_i == 4'h7 && !m_cnd_i) begin
            redirect    = 1'b1;
            redirect_pc = m_vala_i;
        end else if (w_icode_i == 4'h9) begin
            redirect    = 1'b1;
            redirect_pc = w_valm_i;
        end
    end

    // Decode the captured instruction bytes against the PC they came from.
    always_comb begin
        dec_icode = data_q[7:4];
        dec_ifun  = data_q[3:0];
        need_regs = 1'b0;
        need_valc = 1'b0;
        ifun_bad  = 1'b0;
        unique case (dec_icode)
            4'h2, 4'h6, 4'hA, 4'hB: need_regs = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                need_regs = 1'b1;
                need_valc = 1'b1;
            end
            4'h7, 4'h8: need_valc = 1'b1;
            default: ;
        endcase
`ifdef FETCH_IFUN_CHECK_EN
        unique case (dec_icode)
            4'h6:       ifun_bad = (dec_ifun > 4'h3);
            4'h2, 4'h7: ifun_bad = (dec_ifun > 4'h6);
            default:    ifun_bad = (dec_ifun != 4'h0);
        endcase
`endif
        // Constant follows the register byte when there is one.
        if (!need_valc) begin
            dec_valc = 64'h0;
        end else if (need_regs) begin
            dec_valc = data_q[79:16];
        end else begin
            dec_valc = data_q[71:8];
        end
        dec_valp = pc_q + 64'd1 + {63'd0, need_regs} + (need_valc ? 64'd8 : 64'd0);
        if (err_q) begin
            dec_stat = StatAdr;
        end else if (dec_icode > 4'hB || ifun_bad) begin
            dec_stat = StatIns;
        end else if (dec_icode == 4'h0) begin
            dec_stat = StatHlt;
        end else begin
            dec_stat = StatAok;
        end
    end

    // Present the decoded instruction in HOLD, otherwise a nop bubble.
    always_comb begin
        f_valid_o  = 1'b0;
        f_icode_o  = 4'h1;
        f_ifun_o   = 4'h0;
        f_ra_o     = 4'hF;
        f_rb_o     = 4'hF;
        f_valc_o   = 64'h0;
        f_valp_o   = 64'h0;
        f_predpc_o = 64'h0;
        f_stat_o   = StatAok;
        if (state_q == StHold) begin
            f_valid_o = 1'b1;
            f_icode_o = dec_icode;
            f_stat_o  = dec_stat;
            if (dec_stat == StatIns || dec_stat == StatAdr) begin
                f_ra_o = 4'h0;
                f_rb_o = 4'h0;
            end else begin
                f_ifun_o   = dec_ifun;
                f_ra_o     = need_regs ? data_q[15:12] : 4'hF;
                f_rb_o     = need_regs ? data_q[11:8] : 4'hF;
                f_valc_o   = dec_valc;
                f_valp_o   = dec_valp;
                f_predpc_o = (dec_icode == 4'h7 || dec_icode == 4'h8) ? dec_valc : dec_valp;
            end
        end
    end

    // Fetch FSM next state and memory request.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        tgt_d          = tgt_q;
        data_d         = data_q;
        err_d          = err_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        unique case (state_q)
            StReq: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ready) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else begin
                        data_d  = imem.imem_rdata;
                        err_d   = imem.imem_err;
                        state_d = StHold;
                    end
                end else if (redirect) begin
                    // Request must stay stable until answered, so park the target.
                    tgt_d   = redirect_pc;
                    state_d = StDrop;
                end
            end
            StDrop: begin
                imem.imem_req = 1'b1;
                if (redirect) begin
                    tgt_d = redirect_pc;
                end
                if (imem.imem_ready) begin
                    pc_d    = redirect ? redirect_pc : tgt_q;
                    state_d = StReq;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StReq;
                end else if (f_stall_i) begin
                    state_d = StHold;
                end else if (dec_stat != StatAok) begin
                    state_d = StHalted;
                end else begin
                    pc_d    = f_predpc_o;
                    state_d = StReq;
                end
            end
            StHalted: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            tgt_q   <= 64'h0;
            data_q  <= 80'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
